// File: rtl/secure_strobe_pkg.sv
// Shared definitions for the strobe frame former and secure_router: word type codes,
// frame-former FSM encodings and the default unlock key.
package secure_strobe_pkg;

    localparam logic [1:0] TYP_HDR  = 2'b00;
    localparam logic [1:0] TYP_DATA = 2'b01;
    localparam logic [1:0] TYP_TAIL = 2'b10;
    localparam logic [1:0] TYP_CSUM = 2'b11;

    localparam logic [3:0] DEFAULT_KEY = 4'b1010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_TAIL,
        ST_CSUM
    } state_t;

    function automatic logic [5:0] mk_word(input logic [1:0] typ, input logic [3:0] pay);
        return {typ, pay};
    endfunction

endpackage

// File: rtl/strobe_frame_former_if.sv
// Nibble ingress handshake plus the strobed 6-bit frame word toward secure_router.
// master = upstream producer / observer side, slave = the frame former.
interface strobe_frame_former_if;

    logic [3:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [5:0] d_out;
    logic       out_strobe;

    modport master (
        output in_data, in_valid, in_last,
        input  in_ready, d_out, out_strobe
    );

    modport slave (
        input  in_data, in_valid, in_last,
        output in_ready, d_out, out_strobe
    );

endinterface

// File: rtl/strobe_fifo.sv
// Purpose: DEPTH x WIDTH circular buffer of {last, nibble} entries with wrapping pointers.
// Latency: a pushed entry is visible at head one cycle later; head is combinational from storage.
// Backpressure: full blocks push (no overwrite); pop on empty is ignored; push+pop in one cycle allowed.
module strobe_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ZERO = '0;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_FULL);
    assign do_push = push && !full;
    assign do_pop  = pop && (count != CNT_ZERO);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/strobe_frame_former.sv
// Purpose: buffer nibbles, emit HDR/DATA../TAIL words (plus CSUM when CHECKSUM_EN is defined).
// Latency: last nibble accepted at edge k -> HDR on d_out after k+1, first DATA after k+2.
// Backpressure: in_ready drops when the FIFO is full or rst is high; output side never stalls.
module strobe_frame_former
    import secure_strobe_pkg::*;
#(
    parameter int         DEPTH   = 4,
    parameter logic [3:0] KEY     = DEFAULT_KEY,
    parameter int         MAX_LEN = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    strobe_frame_former_if.slave  bus
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [3:0]  LEN_LAST = 4'(MAX_LEN - 1);
    localparam logic [AW:0] PEND_ONE = (AW+1)'(1);
    localparam logic [AW:0] PEND_NIL = '0;

    state_t      state;
    state_t      state_nxt;
    logic [5:0]  d_out_q;
    logic [5:0]  d_out_nxt;
    logic        strobe_q;
    logic        strobe_nxt;
    logic [3:0]  wr_len;
    logic [3:0]  rd_len;
    logic [3:0]  rd_len_nxt;
    logic        last_seen;
    logic        last_seen_nxt;
    logic [AW:0] pending;
    logic        full;
    logic        pop;
    logic        push;
    logic        push_last;
    logic        pop_last;
    logic [4:0]  head;
`ifdef CHECKSUM_EN
    logic [3:0]  csum;
    logic [3:0]  csum_nxt;
`endif

    assign bus.in_ready   = !full && !rst;
    assign push           = bus.in_valid && bus.in_ready;
    assign push_last      = bus.in_last || (wr_len == LEN_LAST);
    assign pop_last       = pop && head[4];
    assign bus.d_out      = d_out_q;
    assign bus.out_strobe = strobe_q;

    strobe_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (5)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat ({push_last, bus.in_data}),
        .pop      (pop),
        .head     (head),
        .full     (full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            d_out_q   <= '0;
            strobe_q  <= 1'b0;
            rd_len    <= '0;
            last_seen <= 1'b0;
`ifdef CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            state     <= state_nxt;
            d_out_q   <= d_out_nxt;
            strobe_q  <= strobe_nxt;
            rd_len    <= rd_len_nxt;
            last_seen <= last_seen_nxt;
`ifdef CHECKSUM_EN
            csum      <= csum_nxt;
`endif
        end
    end

    // A frame is started only once its last entry is buffered, so DATA pops never find the FIFO empty.
    always_comb begin
        state_nxt     = state;
        d_out_nxt     = d_out_q;
        strobe_nxt    = strobe_q;
        rd_len_nxt    = rd_len;
        last_seen_nxt = last_seen;
        pop           = 1'b0;
`ifdef CHECKSUM_EN
        csum_nxt      = csum;
`endif
        case (state)
            ST_IDLE: begin
                if (pending != PEND_NIL) begin
                    state_nxt  = ST_HDR;
                    d_out_nxt  = mk_word(TYP_HDR, KEY);
                    strobe_nxt = 1'b1;
                    rd_len_nxt = '0;
`ifdef CHECKSUM_EN
                    csum_nxt   = KEY;
`endif
                end
            end
            ST_HDR: begin
                pop           = 1'b1;
                state_nxt     = ST_DATA;
                d_out_nxt     = mk_word(TYP_DATA, head[3:0]);
                rd_len_nxt    = 4'd1;
                last_seen_nxt = head[4];
`ifdef CHECKSUM_EN
                csum_nxt      = csum ^ head[3:0];
`endif
            end
            ST_DATA: begin
                if (!last_seen) begin
                    pop           = 1'b1;
                    d_out_nxt     = mk_word(TYP_DATA, head[3:0]);
                    rd_len_nxt    = rd_len + 4'd1;
                    last_seen_nxt = head[4];
`ifdef CHECKSUM_EN
                    csum_nxt      = csum ^ head[3:0];
`endif
                end else begin
                    state_nxt = ST_TAIL;
                    d_out_nxt = mk_word(TYP_TAIL, rd_len);
                end
            end
            ST_TAIL: begin
`ifdef CHECKSUM_EN
                state_nxt  = ST_CSUM;
                d_out_nxt  = mk_word(TYP_CSUM, csum);
`else
                state_nxt  = ST_IDLE;
                d_out_nxt  = '0;
                strobe_nxt = 1'b0;
`endif
            end
            default: begin
                state_nxt  = ST_IDLE;
                d_out_nxt  = '0;
                strobe_nxt = 1'b0;
            end
        endcase
    end

    // wr_len tracks the frame being written; pending counts complete frames still buffered.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_len  <= '0;
            pending <= '0;
        end else begin
            if (push) begin
                wr_len <= push_last ? 4'd0 : wr_len + 4'd1;
            end
            if (push && push_last && !pop_last) begin
                pending <= pending + PEND_ONE;
            end else if (pop_last && !(push && push_last)) begin
                pending <= pending - PEND_ONE;
            end
        end
    end

endmodule

// File: tb/tb_strobe_frame_former.sv
// Bench for strobe_frame_former: frame vector table plus hand-written latency, full-FIFO and reset sequences.
module tb_strobe_frame_former;
    import secure_strobe_pkg::*;

    localparam int         DEPTH   = 4;
    localparam int         MAX_LEN = 4;
    localparam logic [3:0] KEY     = DEFAULT_KEY;

    logic clk;
    logic rst;

    strobe_frame_former_if bus ();

    strobe_frame_former #(
        .DEPTH   (DEPTH),
        .KEY     (KEY),
        .MAX_LEN (MAX_LEN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int         checks   = 0;
    int         failures = 0;
    logic [5:0] expq[$];
    logic       mon_en      = 1'b0;
    logic       prev_strobe = 1'b0;
    logic [3:0] acc         = '0;

    typedef struct packed {
        logic [3:0]  n;
        logic [31:0] nib;
        logic [7:0]  lastm;
        logic [3:0]  nw;
        logic [71:0] w;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Queue an expected word; a TAIL is followed by its checksum word when CHECKSUM_EN is defined.
    task automatic exp_push(input logic [5:0] w);
        if (w[5:4] == TYP_HDR) acc = KEY;
        else if (w[5:4] == TYP_DATA) acc = acc ^ w[3:0];
        expq.push_back(w);
`ifdef CHECKSUM_EN
        if (w[5:4] == TYP_TAIL) expq.push_back({TYP_CSUM, acc});
`endif
    endtask

    task automatic push(input logic [3:0] d, input logic l);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("push_ready_timeout", 32'(n), 32'd0);
        else begin
            @(posedge clk);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((expq.size() != 0 || bus.out_strobe) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(expq.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic run_vec(input int i);
        for (int k = 0; k < int'(vecs[i].nw); k++) exp_push(vecs[i].w[k*6 +: 6]);
        for (int k = 0; k < int'(vecs[i].n); k++) push(vecs[i].nib[k*4 +: 4], vecs[i].lastm[k]);
        drain();
    endtask

    // Scoreboard monitor: every strobed word must match the queue head; idle cycles must show zero.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.out_strobe) begin
                chk("word_expected", 32'(expq.size() != 0), 32'd1);
                if (expq.size() != 0) chk("frame_word", 32'(bus.d_out), 32'(expq.pop_front()));
                if (bus.d_out[5:4] == TYP_HDR) chk("idle_gap", 32'(prev_strobe), 32'd0);
            end else begin
                chk("idle_zero", 32'(bus.d_out), 32'd0);
            end
        end
        prev_strobe <= bus.out_strobe;
    end

    initial begin
        int   n;
        logic seen;

        if (DEPTH < MAX_LEN) begin
            $display("FAIL depth_vs_max_len: DEPTH %0d below MAX_LEN %0d", DEPTH, MAX_LEN);
            $fatal(1, "bad parameters");
        end

        vecs[0] = '{n: 4'd1, nib: 32'h0000_0003, lastm: 8'h01, nw: 4'd3,
                    w: 72'({6'b100001, 6'b010011, 6'b001010})};
        vecs[1] = '{n: 4'd4, nib: 32'h0000_90C5, lastm: 8'h08, nw: 4'd6,
                    w: 72'({6'b100100, 6'b011001, 6'b010000, 6'b011100, 6'b010101, 6'b001010})};
        vecs[2] = '{n: 4'd6, nib: 32'h0076_4321, lastm: 8'h20, nw: 4'd10,
                    w: 72'({6'b100010, 6'b010111, 6'b010110, 6'b001010,
                            6'b100100, 6'b010100, 6'b010011, 6'b010010, 6'b010001, 6'b001010})};
        vecs[3] = '{n: 4'd2, nib: 32'h0000_0021, lastm: 8'h02, nw: 4'd4,
                    w: 72'({6'b100010, 6'b010010, 6'b010001, 6'b001010})};
        vecs[4] = '{n: 4'd4, nib: 32'h0000_FFFF, lastm: 8'h08, nw: 4'd6,
                    w: 72'({6'b100100, 6'b011111, 6'b011111, 6'b011111, 6'b011111, 6'b001010})};

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_d_out", 32'(bus.d_out), 32'd0);
        chk("rst_strobe", 32'(bus.out_strobe), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
        #1;
        chk("ready_after_rst", 32'(bus.in_ready), 32'd1);
        @(negedge clk);

        // Single-nibble frame: HDR one edge after the accepting edge, DATA one edge later.
        exp_push(6'b001010);
        exp_push(6'b010011);
        exp_push(6'b100001);
        bus.in_valid = 1'b1;
        bus.in_data  = 4'h3;
        bus.in_last  = 1'b1;
        chk("ready_idle", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        chk("pre_hdr_strobe", 32'(bus.out_strobe), 32'd0);
        @(posedge clk);
        #1;
        chk("hdr_latency", 32'({bus.out_strobe, bus.d_out}), 32'({1'b1, 6'b001010}));
        @(posedge clk);
        #1;
        chk("data_latency", 32'({bus.out_strobe, bus.d_out}), 32'({1'b1, 6'b010011}));
        drain();

        for (int i = 0; i < 5; i++) run_vec(i);

        // Full FIFO: four nibbles, the fourth implicitly last; a held push must not overwrite.
        exp_push(6'b001010);
        exp_push(6'b010001);
        exp_push(6'b010010);
        exp_push(6'b010011);
        exp_push(6'b010100);
        exp_push(6'b100100);
        exp_push(6'b001010);
        exp_push(6'b011001);
        exp_push(6'b011010);
        exp_push(6'b100010);
        push(4'h1, 1'b0);
        push(4'h2, 1'b0);
        push(4'h3, 1'b0);
        push(4'h4, 1'b0);
        chk("full_ready", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = 4'hE;
        bus.in_last  = 1'b1;
        @(negedge clk);
        chk("full_ready_hdr", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        chk("ready_after_pop", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        push(4'h9, 1'b0);
        push(4'hA, 1'b1);
        drain();

        // Reset during DATA: outputs clear on the next edge and the frame is abandoned.
        mon_en = 1'b0;
        push(4'h7, 1'b0);
        push(4'h8, 1'b0);
        push(4'h9, 1'b1);
        n = 0;
        while (!(bus.out_strobe && bus.d_out == 6'b010111) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("see_first_data", 32'(n < 50), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_d_out", 32'(bus.d_out), 32'd0);
        chk("midrst_strobe", 32'(bus.out_strobe), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_release", 32'(bus.in_ready), 32'd1);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_strobe) seen = 1'b1;
        end
        chk("no_tail_after_rst", 32'(seen), 32'd0);
        mon_en = 1'b1;

        run_vec(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
